// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: lets two requesters share a single combinational ALU.
// Round-robin arbitration picks a requester, the operands are registered
// toward the ALU, the result and compare flags are captured one cycle later,
// and a response is held until the consumer takes it.
module alu_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [1:0]       alu_compare,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [1:0]       resp_compare,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_alu_data1;
  logic [WIDTH-1:0] r_alu_data2;
  logic [OPW-1:0]   r_alu_op;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic [WIDTH-1:0] r_resp_result;
  logic [1:0]       r_resp_compare;
  logic             r_busy;
  logic [CNTW-1:0]  r_op_count;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_hs0;
  logic w_hs1;

  // A lone valid requester always wins; on a tie the one not served last wins.
  assign w_idle   = (r_state == S_IDLE);
  assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_hs0    = w_idle & w_grant0;
  assign w_hs1    = w_idle & w_grant1;

  assign req0_ready   = w_hs0;
  assign req1_ready   = w_hs1;
  assign alu_data1    = r_alu_data1;
  assign alu_data2    = r_alu_data2;
  assign alu_op       = r_alu_op;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_result  = r_resp_result;
  assign resp_compare = r_resp_compare;
  assign busy         = r_busy;
  assign op_count     = r_op_count;

  // Control FSM: accept a request, let the ALU settle one cycle, hold the response until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_last_grant   <= 1'b1;
      r_alu_data1    <= '0;
      r_alu_data2    <= '0;
      r_alu_op       <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= 1'b0;
      r_resp_result  <= '0;
      r_resp_compare <= '0;
      r_busy         <= 1'b0;
      r_op_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs0 || w_hs1) begin
            // Operands stay in these registers after completion so the ALU inputs never glitch.
            r_alu_data1  <= w_hs1 ? req1_a  : req0_a;
            r_alu_data2  <= w_hs1 ? req1_b  : req0_b;
            r_alu_op     <= w_hs1 ? req1_op : req0_op;
            r_resp_id    <= w_hs1;
            r_last_grant <= w_hs1;
            r_busy       <= 1'b1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_resp_result  <= alu_result;
          r_resp_compare <= alu_compare;
          r_resp_valid   <= 1'b1;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_op_count   <= r_op_count + {{(CNTW-1){1'b0}}, 1'b1};
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU attached.
module tb_alu_share_ctrl;
  localparam int WIDTH = 32;
  localparam int OPW   = 3;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [WIDTH-1:0] alu_data1, alu_data2;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic [1:0]       alu_compare;
  logic             resp_valid, resp_ready, resp_id;
  logic [WIDTH-1:0] resp_result;
  logic [1:0]       resp_compare;
  logic             busy;
  logic [CNTW-1:0]  op_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [CNTW-1:0] exp_count;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_compare(alu_compare),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_compare(resp_compare),
    .busy(busy), .op_count(op_count)
  );

  // Behavioural ALU driven by the registered operands
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_data1 + alu_data2;
      3'b001:  alu_result = alu_data1 - alu_data2;
      3'b010:  alu_result = alu_data1 | alu_data2;
      3'b100:  alu_result = alu_data2 << 16;
      default: alu_result = '0;
    endcase
    if (alu_data1 == alu_data2)     alu_compare = 2'b00;
    else if (alu_data1 < alu_data2) alu_compare = 2'b01;
    else                            alu_compare = 2'b10;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from a single requester, starting in IDLE
  task automatic run_op(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [1:0] exp_c, input string tag);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    resp_ready = 1'b1;
    #1;
    check({tag, " ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, " exec_busy"}, 32'(busy), 32'd1);
    check({tag, " exec_no_resp"}, 32'(resp_valid), 32'd0);
    tick();
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " resp_id"}, 32'(resp_id), 32'(id));
    check({tag, " result"}, resp_result, exp_r);
    check({tag, " compare"}, 32'(resp_compare), 32'(exp_c));
    tick();
    exp_count = exp_count + 1'b1;
    check({tag, " idle_resp"}, 32'(resp_valid), 32'd0);
    check({tag, " op_count"}, 32'(op_count), 32'(exp_count));
    $display("txn %s id=%0d op=%0d a=0x%08h b=0x%08h result=0x%08h cmp=%0d count=%0d",
             tag, id, op, a, b, resp_result, resp_compare, op_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b0;
    exp_count = '0;
    tick(); tick();

    // Reset state
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst op_count", 32'(op_count), 32'd0);
    check("rst alu_data1", alu_data1, 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check("rst resp_result", resp_result, 32'd0);
    reset = 1'b1;
    tick();

    // Test 1 and 2: single requesters
    run_op(1'b0, 3'b000, 32'd5, 32'd3, 32'd8, 2'b10, "t1");
    run_op(1'b1, 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 2'b01, "t2");
    check("hold alu_data1", alu_data1, 32'd3);
    check("hold alu_data2", alu_data2, 32'd5);
    check("hold alu_op", 32'(alu_op), 32'd1);

    // Test 3: both valid from reset, grants alternate 0,1,0,1 at one op per 3 cycles
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_count = '0;
    tick();
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 32'd0;         req1_b = 32'h0000_1234;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3 ready0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t3 ready1", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check("t3 busy", 32'(busy), 32'd1);
      tick();
      check("t3 resp_id", 32'(resp_id), (k % 2 == 1) ? 32'd1 : 32'd0);
      check("t3 result", resp_result, (k % 2 == 1) ? 32'h1234_0000 : 32'h0000_00FF);
      $display("txn t3 k=%0d id=%0d result=0x%08h", k, resp_id, resp_result);
      tick();
      exp_count = exp_count + 1'b1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t3 op_count", 32'(op_count), 32'(exp_count));

    // Test 4: back-pressure in RESP
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd1;
    #1;
    check("t4 ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'd9; req1_b = 32'd4;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t4 resp_valid", 32'(resp_valid), 32'd1);
      check("t4 result", resp_result, 32'd2);
      check("t4 compare", 32'(resp_compare), 32'd0);
      check("t4 ready1", 32'(req1_ready), 32'd0);
      check("t4 busy", 32'(busy), 32'd1);
      tick();
    end
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    exp_count = exp_count + 1'b1;
    check("t4 idle busy", 32'(busy), 32'd0);
    check("t4 idle resp", 32'(resp_valid), 32'd0);
    check("t4 op_count", 32'(op_count), 32'(exp_count));
    $display("txn t4 stalled response accepted count=%0d", op_count);

    // Test 5: reset during EXEC discards the operation
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd7; req0_b = 32'd7;
    #1;
    tick();
    req0_valid = 1'b0;
    check("t5 exec busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t5 rst resp_valid", 32'(resp_valid), 32'd0);
    check("t5 rst busy", 32'(busy), 32'd0);
    check("t5 rst op_count", 32'(op_count), 32'd0);
    exp_count = '0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5 no resp", 32'(resp_valid), 32'd0);
      check("t5 idle", 32'(busy), 32'd0);
    end
    $display("txn t5 reset mid-operation, no response");

    // Test 6: 16 completions wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      run_op(1'(i % 2), 3'b000, 32'(i), 32'd1, 32'(i + 1),
             (i == 1) ? 2'b00 : ((i < 1) ? 2'b01 : 2'b10), "t6");
      if (i == 14) check("t6 count15", 32'(op_count), 32'd15);
    end
    check("t6 wrap", 32'(op_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
